// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: frames PS/2 mouse bytes into packets and tracks a screen-bounded cursor; define PS2_MOUSE_WHEEL_EN for 4-byte wheel packets
module ps2_mouse_tracker #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int Z_W         = 8,
  parameter int SCALE_SHIFT = 0,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           iEn,
  input  logic [7:0]     iByte,
  output logic           oTrig,
  output logic [X_W-1:0] oX,
  output logic [Y_W-1:0] oY,
  output logic           oL,
  output logic           oR,
  output logic           oM,
  output logic [Z_W-1:0] oZ,
  output logic           oSyncErr
);
  localparam int W  = (X_W > Y_W ? X_W : Y_W) + 2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic signed [W-1:0] X_MAX = W'(SCREEN_W - 1);
  localparam logic signed [W-1:0] Y_MAX = W'(SCREEN_H - 1);
  localparam logic [1:0] S_B0 = 2'd0;
  localparam logic [1:0] S_B1 = 2'd1;
  localparam logic [1:0] S_B2 = 2'd2;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam logic [1:0] S_B3 = 2'd3;
  localparam logic [1:0] S_END = S_B3;
`else
  localparam logic [1:0] S_END = S_B2;
`endif
  logic [1:0] state, nxt;
  logic [TW-1:0] cnt;
  logic [6:0] hdr;
  logic [7:0] b1, c2;
  logic busy, tmo, commit, bad;
  logic signed [W-1:0] rx, ry, sx, sy, xw, yw, nx, ny;
  logic [X_W-1:0] new_x;
  logic [Y_W-1:0] new_y;
  // state register
  always_ff @(posedge CLOCK) state <= !RESET ? S_B0 : nxt;
  // next state: header gate in S_B0, then walk the bytes, drop back on timeout
  always_comb nxt = iEn ? (state == S_B0 ? (iByte[3] ? S_B1 : S_B0) : state == S_END ? S_B0 : state + 2'd1)
                        : tmo ? S_B0 : state;
  // FSM-derived strobes; a byte arriving on the timeout cycle suppresses the timeout
  always_comb begin
    busy   = state != S_B0;
    tmo    = busy && !iEn && cnt == T_LAST;
    commit = iEn && state == S_END;
    bad    = iEn && state == S_B0 && !iByte[3];
  end
  // delta decode and clamped cursor update in a width that cannot wrap
  always_comb begin
    rx    = hdr[5] ? '0 : {{(W-9){hdr[3]}}, hdr[3], b1};
    ry    = hdr[6] ? '0 : {{(W-9){hdr[4]}}, hdr[4], c2};
    sx    = rx >>> SCALE_SHIFT;
    sy    = ry >>> SCALE_SHIFT;
    xw    = {{(W-X_W){1'b0}}, oX};
    yw    = {{(W-Y_W){1'b0}}, oY};
    nx    = xw + sx;
    ny    = yw - sy;
    new_x = nx[W-1] ? '0 : nx > X_MAX ? X_MAX[X_W-1:0] : nx[X_W-1:0];
    new_y = ny[W-1] ? '0 : ny > Y_MAX ? Y_MAX[Y_W-1:0] : ny[Y_W-1:0];
  end
  // assembly registers, timeout counter and committed cursor/button outputs
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      oX       <= X_W'(SCREEN_W / 2);
      oY       <= Y_W'(SCREEN_H / 2);
      oL       <= 1'b0;
      oR       <= 1'b0;
      oM       <= 1'b0;
      oTrig    <= 1'b0;
      oSyncErr <= 1'b0;
      cnt      <= '0;
      hdr      <= '0;
      b1       <= '0;
    end else begin
      oTrig    <= commit;
      oSyncErr <= bad || tmo;
      cnt      <= (iEn || !busy || tmo) ? '0 : cnt + 1'b1;
      if (iEn && state == S_B0) hdr <= {iByte[7:4], iByte[2:0]};
      if (iEn && state == S_B1) b1 <= iByte;
      if (commit) begin
        oX <= new_x;
        oY <= new_y;
        oL <= hdr[0];
        oR <= hdr[1];
        oM <= hdr[2];
      end
    end
  end
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0] b2;
  assign c2 = b2;
  // byte 2 hold and modulo wheel accumulation from the low nibble of byte 3
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      b2 <= '0;
      oZ <= '0;
    end else begin
      if (iEn && state == S_B2) b2 <= iByte;
      if (commit) oZ <= oZ + {{(Z_W-4){iByte[3]}}, iByte[3:0]};
    end
  end
`else
  assign c2 = iByte;
  assign oZ = '0;
`endif
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: directed scoreboard bench for ps2_mouse_tracker (honours PS2_MOUSE_WHEEL_EN)
module tb_ps2_mouse_tracker;
  localparam int TO = 30;
  localparam int SH = 0;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] by = 8'h00;
  logic trig, l, r, m, serr;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] z;
  int errs = 0, checks = 0;
  int mx = 320, my = 240, ml = 0, mr = 0, mm = 0, mz = 0;
  typedef struct {int x; int y; int l; int r; int m; int z;} exp_t;
  exp_t q[$];

  ps2_mouse_tracker #(.SCALE_SHIFT(SH), .TIMEOUT_CYC(TO)) dut (
    .CLOCK(clk), .RESET(rst_n), .iEn(en), .iByte(by), .oTrig(trig),
    .oX(x), .oY(y), .oL(l), .oR(r), .oM(m), .oZ(z), .oSyncErr(serr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    en = 1'b1;
    by = b;
    @(negedge clk);
    en = 1'b0;
  endtask

  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction

  task automatic model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    int dx, dy, dz;
    exp_t e;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    dx = dx >>> SH;
    dy = dy >>> SH;
    mx = clampi(mx + dx, 639);
    my = clampi(my - dy, 479);
    ml = int'(b0[0]);
    mr = int'(b0[1]);
    mm = int'(b0[2]);
`ifdef PS2_MOUSE_WHEEL_EN
    dz = b3[3] ? int'(b3[3:0]) - 16 : int'(b3[3:0]);
    mz = (mz + dz) & 255;
`else
    dz = int'(b3) & 0;
    mz = mz + dz;
`endif
    e = '{mx, my, ml, mr, mm, mz};
    q.push_back(e);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".x"}, x, mx);
    chk({tag, ".y"}, y, my);
    chk({tag, ".l"}, l, ml);
    chk({tag, ".r"}, r, mr);
    chk({tag, ".m"}, m, mm);
    chk({tag, ".z"}, z, mz);
  endtask

  task automatic expect_commit(input string tag);
    int n = 0;
    exp_t e;
    while (trig !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".trig"}, trig, 1);
    chk({tag, ".sbsize"}, q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".x"}, x, e.x);
      chk({tag, ".y"}, y, e.y);
      chk({tag, ".l"}, l, e.l);
      chk({tag, ".r"}, r, e.r);
      chk({tag, ".m"}, m, e.m);
      chk({tag, ".z"}, z, e.z);
    end
    @(negedge clk);
    chk({tag, ".pulse"}, trig, 0);
  endtask

  task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    model(b0, b1, b2, b3);
    put(b0);
    put(b1);
    put(b2);
`ifdef PS2_MOUSE_WHEEL_EN
    put(b3);
`endif
    expect_commit(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_state("rst");
    chk("rst.trig", trig, 0);
    chk("rst.serr", serr, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle.trig", trig, 0);
      chk("idle.serr", serr, 0);
    end
    chk_state("idle");
    pkt("p1", 8'h09, 8'h05, 8'h03, 8'h00);
    pkt("p2", 8'h08, 8'h7F, 8'h00, 8'h00);
    pkt("p3", 8'h08, 8'h7F, 8'h00, 8'h00);
    pkt("p4", 8'h08, 8'h33, 8'h00, 8'h00);
    pkt("clamp", 8'h08, 8'h7F, 8'h00, 8'h00);
    pkt("atmax", 8'h08, 8'h01, 8'h00, 8'h00);
    pkt("neg256", 8'h18, 8'h00, 8'h00, 8'h00);
    put(8'h00);
    chk("bad.serr", serr, 1);
    chk("bad.trig", trig, 0);
    @(negedge clk);
    chk("bad.serr_end", serr, 0);
    pkt("xovf", 8'h48, 8'h50, 8'h10, 8'h00);
    put(8'h08);
    put(8'h10);
    repeat (TO - 1) @(negedge clk);
    chk("to.early", serr, 0);
    @(negedge clk);
    chk("to.fire", serr, 1);
    chk("to.trig", trig, 0);
    chk_state("to");
    @(negedge clk);
    chk("to.end", serr, 0);
    pkt("after_to", 8'h08, 8'h02, 8'h00, 8'h00);
    model(8'h08, 8'h10, 8'h04, 8'h00);
    put(8'h08);
    put(8'h10);
    repeat (TO - 1) @(negedge clk);
    put(8'h04);
    chk("race.serr", serr, 0);
`ifdef PS2_MOUSE_WHEEL_EN
    put(8'h00);
`endif
    expect_commit("race");
`ifdef PS2_MOUSE_WHEEL_EN
    pkt("wheel", 8'h08, 8'h00, 8'h00, 8'h0F);
`endif
    put(8'h0B);
    put(8'h05);
    rst_n = 1'b0;
    @(negedge clk);
    mx = 320; my = 240; ml = 0; mr = 0; mm = 0; mz = 0;
    chk_state("mid_rst");
    chk("mid_rst.trig", trig, 0);
    chk("mid_rst.serr", serr, 0);
    rst_n = 1'b1;
    pkt("post_rst", 8'h09, 8'h05, 8'h03, 8'h00);
    chk("sb.drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
